// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback sources and register file write port bundle
interface regfile_wb_arbiter_if;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        register_write_en;
    logic [4:0]  rd_address;
    logic [31:0] register_write_data;
    logic [31:0] pending_mask;
    logic        ex_stall;

    modport master (
        output ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, register_write_en, rd_address, register_write_data,
               pending_mask, ex_stall
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
        output mem_ready, register_write_en, rd_address, register_write_data,
               pending_mask, ex_stall
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write port arbiter; optional starvation guard via WB_ARB_STARVE_GUARD_EN
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [4:0]       fifo_rd   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_live;

    logic [AW-1:0] head_idx, tail_idx;
    logic full, empty, head_live, starve;
    logic ex_take, ex_win, transfer, push, pop, grant_head;

    assign head_idx = rd_ptr[AW-1:0];
    assign tail_idx = wr_ptr[AW-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (head_idx == tail_idx);
    assign head_live = !empty && fifo_live[head_idx];

    // A stalled execute request is not consumed: it neither writes, cancels nor blocks a load.
    assign ex_take    = bus.ex_valid && !starve;
    assign ex_win     = ex_take && (bus.ex_rd != 5'd0);
    assign transfer   = bus.mem_valid && !full;
    assign push       = transfer && (bus.mem_rd != 5'd0) && !(ex_take && bus.ex_rd == bus.mem_rd);
    assign grant_head = head_live && !ex_win;
    assign pop        = !empty && (!fifo_live[head_idx] || grant_head);

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if (head_live && ex_win) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign starve = head_live && (starve_cnt == CW'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_live <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd[i]   <= 5'd0;
                fifo_data[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ex_win && fifo_rd[i] == bus.ex_rd) begin
                    fifo_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                fifo_live[head_idx] <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                fifo_rd[tail_idx]   <= bus.mem_rd;
                fifo_data[tail_idx] <= bus.mem_data;
                fifo_live[tail_idx] <= 1'b1;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        bus.register_write_en   = 1'b0;
        bus.rd_address          = 5'd0;
        bus.register_write_data = 32'd0;
        if (rst) begin
            if (ex_win) begin
                bus.register_write_en   = 1'b1;
                bus.rd_address          = bus.ex_rd;
                bus.register_write_data = bus.ex_data;
            end else if (grant_head) begin
                bus.register_write_en   = 1'b1;
                bus.rd_address          = fifo_rd[head_idx];
                bus.register_write_data = fifo_data[head_idx];
            end
        end
    end

    always_comb begin
        bus.pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live[i]) begin
                bus.pending_mask[fifo_rd[i]] = 1'b1;
            end
        end
        bus.pending_mask[0] = 1'b0;
    end

    assign bus.mem_ready = !full;
    assign bus.ex_stall  = starve;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        @(negedge clk);
        bus.ex_valid  = ev;
        bus.ex_rd     = erd;
        bus.ex_data   = ed;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        #1;
    endtask

    task automatic port(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_en"}, {31'd0, bus.register_write_en}, {31'd0, en});
        chk({tag, "_addr"}, {27'd0, bus.rd_address}, {27'd0, a});
        chk({tag, "_data"}, bus.register_write_data, d);
    endtask

    initial begin
        rst = 1'b0;
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_data = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;

        drive(0, 0, 0, 0, 0, 0);
        port("reset", 0, 0, 0);
        chk("reset_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("reset_mask", bus.pending_mask, 32'd0);
        chk("reset_stall", {31'd0, bus.ex_stall}, 32'd0);
        rst = 1'b1;

        // single load
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        port("load_accept", 0, 0, 0);
        chk("load_ready", {31'd0, bus.mem_ready}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk("load_mask", bus.pending_mask, 32'h20);
        port("load_write", 1, 5'd5, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0);
        chk("load_mask_after", bus.pending_mask, 32'd0);
        port("load_idle", 0, 0, 0);

        // full FIFO under continuous execute traffic
        drive(1, 5'd1, 32'hA1, 1, 5'd2, 32'h2);
        port("full_a", 1, 5'd1, 32'hA1);
        drive(1, 5'd1, 32'hA2, 1, 5'd3, 32'h3);
        chk("full_b_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("full_b_mask", bus.pending_mask, 32'h4);
        drive(1, 5'd1, 32'hA3, 1, 5'd4, 32'h4);
        chk("full_c_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("full_c_mask", bus.pending_mask, 32'hC);
        port("full_c", 1, 5'd1, 32'hA3);
        drive(1, 5'd1, 32'hA4, 1, 5'd4, 32'h4);
        chk("full_d_ready", {31'd0, bus.mem_ready}, 32'd0);
        drive(0, 0, 0, 1, 5'd4, 32'h4);
        chk("full_e_ready", {31'd0, bus.mem_ready}, 32'd0);
        port("full_e", 1, 5'd2, 32'h2);
        drive(0, 0, 0, 1, 5'd4, 32'h4);
        chk("full_f_ready", {31'd0, bus.mem_ready}, 32'd1);
        port("full_f", 1, 5'd3, 32'h3);
        drive(0, 0, 0, 0, 0, 0);
        port("full_g", 1, 5'd4, 32'h4);
        drive(0, 0, 0, 0, 0, 0);
        port("full_h", 0, 0, 0);
        chk("full_h_mask", bus.pending_mask, 32'd0);

        // cancel a queued load by a younger execute write
        drive(0, 0, 0, 1, 5'd7, 32'h77);
        drive(1, 5'd7, 32'h11, 0, 0, 0);
        port("cancel_ex", 1, 5'd7, 32'h11);
        chk("cancel_mask_before", bus.pending_mask, 32'h80);
        drive(0, 0, 0, 0, 0, 0);
        port("cancel_dead", 0, 0, 0);
        chk("cancel_mask", bus.pending_mask, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        port("cancel_after", 0, 0, 0);

        // same-cycle conflict and x0
        drive(1, 5'd9, 32'h55, 1, 5'd9, 32'h99);
        port("conflict", 1, 5'd9, 32'h55);
        chk("conflict_ready", {31'd0, bus.mem_ready}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        port("conflict_after", 0, 0, 0);
        chk("conflict_mask", bus.pending_mask, 32'd0);
        drive(1, 5'd0, 32'h123, 1, 5'd0, 32'h456);
        port("x0", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        port("x0_after", 0, 0, 0);
        chk("x0_mask", bus.pending_mask, 32'd0);

        // starvation: load queued behind continuous execute writes
        drive(1, 5'd1, 32'hE0, 1, 5'd12, 32'hC0);
        port("starve_s0", 1, 5'd1, 32'hE0);
        for (int i = 1; i <= 6; i++) begin
            drive(1, 5'd1, 32'hE0 + i, 0, 0, 0);
            if (GUARD && i == 5) begin
                port($sformatf("starve_l%0d", i), 1, 5'd12, 32'hC0);
                chk($sformatf("starve_stall%0d", i), {31'd0, bus.ex_stall}, 32'd1);
            end else begin
                port($sformatf("starve_l%0d", i), 1, 5'd1, 32'hE0 + i);
                chk($sformatf("starve_stall%0d", i), {31'd0, bus.ex_stall}, 32'd0);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        if (GUARD) port("starve_end", 0, 0, 0);
        else       port("starve_end", 1, 5'd12, 32'hC0);
        drive(0, 0, 0, 0, 0, 0);
        port("starve_idle", 0, 0, 0);

        // reset with two entries queued
        drive(1, 5'd1, 32'hB1, 1, 5'd2, 32'h22);
        drive(1, 5'd1, 32'hB2, 1, 5'd3, 32'h33);
        drive(1, 5'd1, 32'hB3, 0, 0, 0);
        chk("rst_mid_mask_before", bus.pending_mask, 32'hC);
        @(negedge clk);
        bus.ex_valid = 0;
        rst = 1'b0;
        #1;
        port("rst_mid", 0, 0, 0);
        chk("rst_mid_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("rst_mid_mask", bus.pending_mask, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            port($sformatf("rst_post%0d", i), 0, 0, 0);
            chk($sformatf("rst_post_mask%0d", i), bus.pending_mask, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Arbitrates the register file's single write port between two writeback sources:
  - the execute stage (ALU results, never stalled);
  - the memory stage (load data, valid/ready handshake).
- Sits between the pipeline writeback paths and the register file write port (`register_write_en`, `rd_address`, `register_write_data`).
- Memory writes are buffered in a small FIFO. Younger execute writes cancel older queued writes to the same register.
- Exports a pending-write mask so decode can stall on registers with queued writes.

## Interface
- `DEPTH`, 2, memory-write FIFO entries; power of 2, ≥2.
- `STARVE_LIMIT`, 4, cycles a live FIFO head may wait before the guard engages (used only with the guard macro).
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `ex_valid`  in  1  execute writeback request.
- `ex_rd`  in  5  execute destination register.
- `ex_data`  in  32  execute result.
- `mem_valid`  in  1  load writeback request.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  32  load data.
- `mem_ready`  out  1  FIFO can accept a memory write.
- `register_write_en`  out  1  register file write enable.
- `rd_address`  out  5  register file write address.
- `register_write_data`  out  32  register file write data.
- `pending_mask`  out  32  bit i set when a live FIFO entry targets register i; bit 0 is always 0.
- `ex_stall`  out  1  starvation guard request to hold the execute stage.

## Operation
- **FIFO storage:** each entry holds {rd, data, live}. Pointers are $clog2(DEPTH)+1 bits wide, so full and empty are distinguished by the MSB.
- **Memory handshake:**
  - `mem_ready` = !full, computed from registered state only; it does not account for a same-cycle pop.
  - A transfer occurs when `mem_valid && mem_ready`.
- **Enqueue:**
  - Entry is enqueued with live=1.
  - Exceptions: if `mem_rd`==0, or if `ex_valid` with `ex_rd`==`mem_rd` in the same cycle (the execute write is younger), the transfer is still accepted but the entry is not enqueued.
- **Cancel:** when `ex_valid` and `ex_rd`≠0, every queued entry with rd==`ex_rd` is cleared to live=0 at the clock edge.
- **Port priority:**
  1. `ex_valid` with `ex_rd`≠0 wins: the write port drives `ex_rd`/`ex_data`.
  2. Otherwise, a live FIFO head is written and popped.
- **Dead heads:** a head with live=0 is popped without a write, regardless of execute activity. At most one pop per cycle.
- **x0 handling:** execute writes with `ex_rd`==0 are dropped; `register_write_en` stays 0 for them.
- **Idle port:** when no write is issued, `register_write_en`=0, `rd_address`=0, `register_write_data`=0.
- **pending_mask:** combinational OR over live entries of (1<<rd).

## Timing
- **Reset:** asynchronous, `rst`=0 forces:
  - FIFO empty, all live=0, starvation counter 0;
  - `mem_ready`=1, `pending_mask`=0, `ex_stall`=0, and all write-port outputs 0.
  - Reset during buffered traffic discards queued writes without writing them.
- **Latency:**
  - Execute write reaches the port in the same cycle (combinational).
  - Memory write reaches the port no earlier than the cycle after acceptance.
- **Ordering:** live memory writes drain in acceptance order.
- **Full FIFO:** `mem_ready`=0 for the whole cycle, even if a pop happens in that cycle. `mem_ready` returns to 1 in the cycle after the pop.
- **Simultaneous events:**
  - Push and pop in one cycle: both occur; occupancy is unchanged.
  - Cancel and pop of the same entry in one cycle: pop wins, but no write is issued if the execute write holds the port.

## Configuration
- **Macro:** `WB_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A counter increments every cycle the head is live and loses arbitration to an execute write. It resets to 0 whenever the head is popped.
  - When the counter reaches `STARVE_LIMIT`, `ex_stall`=1 combinationally in that cycle.
  - In that cycle the head is granted the port even if `ex_valid`=1. Execute then holds its request, and the arbiter does not consume it that cycle.
- **Undefined:** `ex_stall` is tied to 0; strict execute priority; no counter is instantiated.

## Test plan
- **Reset mid-operation:** reset with 2 entries queued → outputs 0, `mem_ready`=1, `pending_mask`=0; no write occurs after release.
- **Single load:** load rd=5, data=0xDEADBEEF, no execute traffic → `pending_mask`=0x20 next cycle, write rd=5/0xDEADBEEF that cycle, mask 0 after.
- **Full FIFO:** with `ex_valid`=1 to rd=1 every cycle, push 3 loads (rd=2,3,4) → third push sees `mem_ready`=0 until the execute traffic stops; loads then write in order 2, 3, 4.
- **Cancel:** queue load rd=7, then execute writes rd=7 value 0x11 → port writes 0x11; the queued entry is dropped, and no later write to rd=7 occurs.
- **Same-cycle conflict and x0:**
  - `mem_valid` rd=9 and `ex_valid` rd=9 in the same cycle → only the execute write occurs; the load handshake completes.
  - Writes to rd=0 from either source → `register_write_en` never asserted.
- **Starvation guard:** with the macro defined and continuous execute writes, a queued load writes after exactly `STARVE_LIMIT`=4 lost cycles; `ex_stall`=1 for that one cycle. Without the macro, the load never writes while execute traffic continues.
